// File: rtl/vga_display_scaled.sv
// vga_display_scaled: framebuffer-to-VGA display stage.
//   Places a C_IMG_COLS x C_IMG_ROWS image at screen origin (C_ORG_COL, C_ORG_ROW).
//   The image is upscaled x1/x2/x4/x8 by pixel and line replication.
//   Framebuffer addresses come from counters only (no multipliers).
//   Colour and syncs leave exactly one pixel period after the pixel's inputs.
// Ports:
//   rst, clk            async active-high reset, system clock
//   new_pxl             one-clk strobe per pixel period
//   visible/hsync/vsync timing from the sync generator
//   col, row            current screen position
//   rgbmode             1 = RGB444 decode, 0 = grayscale from frame_pixel[7:4]
//   scale               0..3 -> x1/x2/x4/x8, sampled at pixel (0,0)
//   frame_pixel         RAM read data
//   frame_addr          RAM read address (registered)
//   vga_red/green/blue  registered colour
//   vga_hsync/vsync     syncs aligned with the colour outputs
// Build option: define VGA_DISP_BORDER_EN to draw a white 1-pixel frame around the window.
module vga_display_scaled #(
  parameter int              C_IMG_COLS     = 80,
  parameter int              C_IMG_ROWS     = 60,
  parameter int              C_NB_IMG_PXLS  = 13,
  parameter int              C_NB_BUF_RED   = 4,
  parameter int              C_NB_BUF_GREEN = 4,
  parameter int              C_NB_BUF_BLUE  = 4,
  parameter int              C_NB_BUF       = C_NB_BUF_RED + C_NB_BUF_GREEN + C_NB_BUF_BLUE,
  parameter int              C_ORG_COL      = 0,
  parameter int              C_ORG_ROW      = 0,
  parameter logic [11:0]     C_BG_RGB       = 12'h9DC,
  parameter int              C_MEM_LAT      = 1
) (
  input  logic                     rst,
  input  logic                     clk,
  input  logic                     new_pxl,
  input  logic                     visible,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic [9:0]               col,
  input  logic [9:0]               row,
  input  logic                     rgbmode,
  input  logic [1:0]               scale,
  input  logic [C_NB_BUF-1:0]      frame_pixel,
  output logic [C_NB_IMG_PXLS-1:0] frame_addr,
  output logic [3:0]               vga_red,
  output logic [3:0]               vga_green,
  output logic [3:0]               vga_blue,
  output logic                     vga_hsync,
  output logic                     vga_vsync
);

  localparam logic [11:0] ORG_C = 12'(C_ORG_COL);
  localparam logic [11:0] ORG_R = 12'(C_ORG_ROW);
  localparam logic [C_NB_IMG_PXLS-1:0] IMG_COLS = C_NB_IMG_PXLS'(C_IMG_COLS);

  logic [1:0]               scale_q, scale_d;
  logic [2:0]               x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic [C_NB_IMG_PXLS-1:0] x_img_q, x_img_d, line_base_q, line_base_d;
  logic [C_NB_IMG_PXLS-1:0] addr_q, addr_d;
  logic                     win_q, win_d, vis_q, vis_d, hs_q, hs_d, vs_q, vs_d;
  logic [3:0]               red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic                     ohs_q, ohs_d, ovs_q, ovs_d;

  // Window geometry: offsets are 12-bit two's complement so bit 11 flags
  // "left of / above the origin" without a constant compare against zero.
  logic [10:0] win_w, win_h;
  logic [11:0] col_off, row_off;
  logic        col_in, row_in, in_win, col_last;
  logic [2:0]  s_m1;

  assign win_w    = 11'(C_IMG_COLS) << scale_q;
  assign win_h    = 11'(C_IMG_ROWS) << scale_q;
  assign col_off  = {2'b00, col} - ORG_C;
  assign row_off  = {2'b00, row} - ORG_R;
  assign col_in   = !col_off[11] && (col_off[10:0] < win_w);
  assign row_in   = !row_off[11] && (row_off[10:0] < win_h);
  assign in_win   = col_in && row_in;
  assign col_last = col_in && (col_off[10:0] == win_w - 11'd1);
  assign s_m1     = 3'((4'd1 << scale_q) - 4'd1);

`ifdef VGA_DISP_BORDER_EN
  // Outline one pixel outside the window; offset -1 only exists when origin >= 1.
  logic col_edge, row_edge, col_span, row_span, border, bord_q, bord_d;
  assign col_edge = (col_off == 12'hFFF) || (!col_off[11] && col_off[10:0] == win_w);
  assign row_edge = (row_off == 12'hFFF) || (!row_off[11] && row_off[10:0] == win_h);
  assign col_span = (col_off == 12'hFFF) || (!col_off[11] && col_off[10:0] <= win_w);
  assign row_span = (row_off == 12'hFFF) || (!row_off[11] && row_off[10:0] <= win_h);
  assign border   = (col_edge && row_span) || (row_edge && col_span);
`endif

  always_comb begin
    scale_d     = scale_q;
    x_sub_d     = x_sub_q;
    x_img_d     = x_img_q;
    y_sub_d     = y_sub_q;
    line_base_d = line_base_q;
    addr_d      = addr_q;
    win_d = win_q; vis_d = vis_q; hs_d = hs_q; vs_d = vs_q;
    red_d = red_q; grn_d = grn_q; blu_d = blu_q;
    ohs_d = ohs_q; ovs_d = ovs_q;
`ifdef VGA_DISP_BORDER_EN
    bord_d = bord_q;
`endif
    if (new_pxl) begin
      // New scale only steers the pixels after (0,0).
      if (row == 10'd0 && col == 10'd0) scale_d = scale;

      if (!col_in) begin
        x_sub_d = '0;
        x_img_d = '0;
      end else if (in_win) begin
        addr_d = line_base_q + x_img_q;
        if (x_sub_q == s_m1) begin
          x_sub_d = '0;
          x_img_d = x_img_q + 1'b1;
        end else begin
          x_sub_d = x_sub_q + 3'd1;
        end
      end

      if (!row_in) begin
        y_sub_d     = '0;
        line_base_d = '0;
      end else if (in_win && col_last) begin
        if (y_sub_q == s_m1) begin
          y_sub_d     = '0;
          line_base_d = line_base_q + IMG_COLS;
        end else begin
          y_sub_d = y_sub_q + 3'd1;
        end
      end

      // Output stage: previous pixel's attributes plus the RAM word it fetched.
      ohs_d = hs_q;
      ovs_d = vs_q;
      if (!vis_q) begin
        {red_d, grn_d, blu_d} = 12'h000;
      end else if (win_q) begin
        if (rgbmode) begin
          red_d = frame_pixel[C_NB_BUF-1 -: 4];
          grn_d = frame_pixel[C_NB_BUF_BLUE+C_NB_BUF_GREEN-1 -: 4];
          blu_d = frame_pixel[C_NB_BUF_BLUE-1 -: 4];
        end else begin
          red_d = frame_pixel[7:4];
          grn_d = frame_pixel[7:4];
          blu_d = frame_pixel[7:4];
        end
`ifdef VGA_DISP_BORDER_EN
      end else if (bord_q) begin
        {red_d, grn_d, blu_d} = 12'hFFF;
`endif
      end else begin
        {red_d, grn_d, blu_d} = C_BG_RGB;
      end

      win_d = in_win; vis_d = visible; hs_d = hsync; vs_d = vsync;
`ifdef VGA_DISP_BORDER_EN
      bord_d = border;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scale_q <= '0; x_sub_q <= '0; x_img_q <= '0; y_sub_q <= '0;
      line_base_q <= '0; addr_q <= '0;
      win_q <= 1'b0; vis_q <= 1'b0; hs_q <= 1'b1; vs_q <= 1'b1;
      red_q <= '0; grn_q <= '0; blu_q <= '0;
      ohs_q <= 1'b1; ovs_q <= 1'b1;
`ifdef VGA_DISP_BORDER_EN
      bord_q <= 1'b0;
`endif
    end else begin
      scale_q <= scale_d; x_sub_q <= x_sub_d; x_img_q <= x_img_d; y_sub_q <= y_sub_d;
      line_base_q <= line_base_d; addr_q <= addr_d;
      win_q <= win_d; vis_q <= vis_d; hs_q <= hs_d; vs_q <= vs_d;
      red_q <= red_d; grn_q <= grn_d; blu_q <= blu_d;
      ohs_q <= ohs_d; ovs_q <= ovs_d;
`ifdef VGA_DISP_BORDER_EN
      bord_q <= bord_d;
`endif
    end
  end

  assign frame_addr = addr_q;
  assign vga_red    = red_q;
  assign vga_green  = grn_q;
  assign vga_blue   = blu_q;
  assign vga_hsync  = ohs_q;
  assign vga_vsync  = ovs_q;

endmodule

// File: doc/vga_display_scaled.md
Name: vga_display_scaled

Overview:
- Next-generation framebuffer-to-VGA display stage.
- Places a C_IMG_COLS x C_IMG_ROWS image at a parametrised screen origin, with run-time integer upscaling of x1/x2/x4/x8 by pixel and line replication.
- Generates framebuffer read addresses with counters only, with no multipliers, and pipelines colour and syncs so all VGA outputs stay aligned regardless of memory read latency.
- Sits between the VGA sync generator (col/row/new_pxl) and the framebuffer RAM read port.

Parameters:
- C_IMG_COLS, 80, image width in pixels
- C_IMG_ROWS, 60, image height in lines
- C_NB_IMG_PXLS, 13, frame_addr width (ceil log2 of cols*rows)
- C_NB_BUF_RED / C_NB_BUF_GREEN / C_NB_BUF_BLUE, 4/4/4, colour field widths in a memory word
- C_NB_BUF, sum of the three, memory word width
- C_ORG_COL, 0, screen column of the window's left edge
- C_ORG_ROW, 0, screen row of the window's top edge
- C_BG_RGB, 12'h9DC, background colour {r,g,b} for visible pixels outside the window
- C_MEM_LAT, 1, framebuffer read latency in clk cycles (1..3)

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  system clock
- new_pxl  in  1  one-clk strobe per pixel period
- visible  in  1  active video area
- hsync, vsync  in  1 each  sync inputs from the generator
- col  in  10  current screen column
- row  in  10  current screen row
- rgbmode  in  1  1 = RGB444 decode; 0 = grayscale from frame_pixel[7:4]
- scale  in  2  0/1/2/3 selects x1/x2/x4/x8
- frame_pixel  in  C_NB_BUF  RAM read data
- frame_addr  out  C_NB_IMG_PXLS  RAM read address (registered)
- vga_red, vga_green, vga_blue  out  4 each  registered colour outputs
- vga_hsync, vga_vsync  out  1 each  syncs delayed to match the colour outputs

Behaviour:
- Reset values: frame_addr, vga_* colour outputs, all counters and scale_q are 0; vga_hsync and vga_vsync are 1 (idle level).
- Scale sampling:
  - scale is captured into scale_q on new_pxl when row==0 and col==0 only.
  - A mid-frame change takes effect the next frame.
- Window:
  - S = 1<<scale_q; W = C_IMG_COLS*S; H = C_IMG_ROWS*S, each formed by shift.
  - in_win = (C_ORG_COL <= col < C_ORG_COL+W) and (C_ORG_ROW <= row < C_ORG_ROW+H).
  - Comparisons use 11-bit sums; a window extending past the visible area is clipped, with no wrap.
- Counters are x_sub, x_img, y_sub and line_base, and all advance only on new_pxl.
  - col outside the window column range: x_sub=0, x_img=0.
  - in_win: frame_addr <= line_base + x_img. x_sub increments; when x_sub reaches S-1 it wraps to 0 and x_img increments.
  - in_win and col == C_ORG_COL+W-1: y_sub increments; when it reaches S-1 it wraps to 0 and line_base += C_IMG_COLS.
  - row outside the window row range: y_sub=0, line_base=0.
  - frame_addr holds its value on pixels that are not in_win.
- Pipeline:
  - On new_pxl, stage0 <= {in_win, visible, hsync, vsync}.
  - On the next new_pxl, outputs load from stage0 and frame_pixel. Latency is exactly one pixel period for colour and sync alike.
  - Constraint: the new_pxl period must be at least C_MEM_LAT+1 clk.
- Colour select (registered at output load):
  - !visible: all colour outputs 0.
  - visible && in_win && rgbmode: red = frame_pixel[C_NB_BUF-1 -: 4], green = middle field, blue = low field.
  - visible && in_win && !rgbmode: all three channels = frame_pixel[7:4].
  - visible && !in_win: C_BG_RGB.
- Simultaneous events: row==0/col==0 scale capture and window evaluation on the same new_pxl use the new scale_q from the following pixel onward.
- Reset mid-frame: outputs go to reset values; correct output resumes at the first window pixel of the next frame.

Optional Feature:
- Macro: VGA_DISP_BORDER_EN.
- Defined: a 1-pixel frame just outside the window is drawn in white (F,F,F) when visible. Frame pixels are col==C_ORG_COL-1 or C_ORG_COL+W, or row==C_ORG_ROW-1 or C_ORG_ROW+H, each only where that index is ≥0.
- Undefined: those pixels show C_BG_RGB; no extra logic.

Test Plan:
- x1, origin (0,0), RAM data = addr: pixel (5,2) → frame_addr 165; vga_* = RAM[165] fields one new_pxl later; pixel (80,0) → 9,D,C.
- x2: pixels (0..1, 0..1) → frame_addr 0; pixel (2,0) → 1; row 2 col 0 → 80; last window pixel (159,119) → 4799.
- x4 with C_ORG_COL=100, C_ORG_ROW=50: (99,50) → bg; (100,50) → addr 0; (419,289) → 4799; (420,289) → bg.
- rgbmode=0, frame_pixel=12'h3A7 → R=G=B=A; rgbmode=1 → R=3, G=A, B=7; visible=0 → 0,0,0.
- scale changed 0→3 at row 30: addresses continue x1 until the next frame's (0,0), then x8; hsync/vsync outputs lag the inputs by exactly one new_pxl.
- With VGA_DISP_BORDER_EN, origin (10,10), x1: (9,10) → F,F,F and (90,70) → F,F,F; async rst pulse mid-line → outputs 0 and syncs 1 immediately.
